// File: rtl/btn_conditioner.sv
// Button/switch input conditioner: 2-flop synchronizers, per-button debouncers,
// rise pulses, pause toggle, gated jump/duck controls and registered level select.
module btn_conditioner #(
  parameter int unsigned DB_CYCLES = 500000,
  parameter int unsigned CW        = $clog2(DB_CYCLES)
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       pause,
  input  logic       jump,
  input  logic       duck,
  input  logic       chooselvl,
  input  logic       adj,
  input  logic [2:0] num,
  output logic       paused,
  output logic       jump_p,
  output logic       duck_l,
  output logic [2:0] level,
  output logic       level_chg
);

  localparam int NB = 5;
  localparam int BPause  = 0;
  localparam int BJump   = 1;
  localparam int BDuck   = 2;
  localparam int BChoose = 3;
  localparam int BAdj    = 4;

  localparam logic [CW-1:0] CntMax = CW'(DB_CYCLES - 1);

  logic [NB-1:0] raw;
  logic [NB-1:0] s1_q, s2_q;
  logic [2:0]    num_s1_q, num_s2_q;

  logic [NB-1:0] db_q, db_d;
  logic [NB-1:0] db_dly_q;
  logic [CW-1:0] cnt_q [NB];
  logic [CW-1:0] cnt_d [NB];
  logic [NB-1:0] rise;

  logic       paused_q, paused_d;
  logic [2:0] level_q, level_d;
  logic [2:0] level_prev_q;
  logic       level_chg_q;

  assign raw = {adj, chooselvl, duck, jump, pause};

  always_ff @(posedge clk) begin
    if (clr) begin
      s1_q     <= '0;
      s2_q     <= '0;
      num_s1_q <= '0;
      num_s2_q <= '0;
    end else begin
      s1_q     <= raw;
      s2_q     <= s1_q;
      num_s1_q <= num;
      num_s2_q <= num_s1_q;
    end
  end

  // A mismatch must persist DB_CYCLES edges; any agreement restarts the window.
  always_comb begin
    db_d = db_q;
    for (int i = 0; i < NB; i++) begin
      cnt_d[i] = cnt_q[i];
      if (s2_q[i] == db_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CntMax) begin
        db_d[i]  = ~db_q[i];
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      db_q     <= '0;
      db_dly_q <= '0;
      for (int i = 0; i < NB; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      db_q     <= db_d;
      db_dly_q <= db_q;
      for (int i = 0; i < NB; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign rise = db_q & ~db_dly_q;

  assign paused_d = paused_q ^ rise[BPause];

  // Level actions see the pre-toggle pause state; adj has priority over chooselvl.
  always_comb begin
    level_d = level_q;
    if (paused_q) begin
      if (rise[BAdj]) begin
        level_d = (num_s2_q == 3'd0) ? 3'd1 : num_s2_q;
      end else if (rise[BChoose]) begin
        level_d = (level_q == 3'd7) ? 3'd1 : level_q + 3'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      paused_q     <= 1'b1;
      level_q      <= 3'd1;
      level_prev_q <= 3'd1;
      level_chg_q  <= 1'b0;
    end else begin
      paused_q     <= paused_d;
      level_q      <= level_d;
      level_prev_q <= level_q;
      level_chg_q  <= (level_q != level_prev_q);
    end
  end

  assign paused    = paused_q;
  assign jump_p    = rise[BJump] & ~paused_q;
  assign duck_l    = db_q[BDuck] & ~paused_q;
  assign level     = level_q;
  assign level_chg = level_chg_q;

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner with DB_CYCLES=4; inputs change 1 time unit after
// each rising edge and outputs are sampled at the same point.
module tb_btn_conditioner;

  localparam int BPause  = 0;
  localparam int BJump   = 1;
  localparam int BDuck   = 2;
  localparam int BChoose = 3;
  localparam int BAdj    = 4;

  logic       clk;
  logic       clr;
  logic [4:0] btn;
  logic [2:0] num;
  logic       paused, jump_p, duck_l, level_chg;
  logic [2:0] level;

  int checks = 0;
  int errors = 0;
  int jp_cnt = 0;
  int lc_cnt = 0;

  btn_conditioner #(.DB_CYCLES(4)) dut (
    .clk       (clk),
    .clr       (clr),
    .pause     (btn[BPause]),
    .jump      (btn[BJump]),
    .duck      (btn[BDuck]),
    .chooselvl (btn[BChoose]),
    .adj       (btn[BAdj]),
    .num       (num),
    .paused    (paused),
    .jump_p    (jump_p),
    .duck_l    (duck_l),
    .level     (level),
    .level_chg (level_chg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (jump_p) jp_cnt++;
    if (level_chg) lc_cnt++;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic press(input int idx);
    btn[idx] = 1'b1;
    ticks(16);
    btn[idx] = 1'b0;
    ticks(8);
  endtask

  int       jp0, lc0;
  logic [7:0] pat;
  logic [2:0] exp_lvl;

  initial begin
    clr = 1'b1;
    btn = 5'h1f;
    num = 3'd7;
    ticks(3);
    check("rst_paused", paused, 1);
    check("rst_level", level, 1);
    check("rst_jump_p", jump_p, 0);
    check("rst_duck_l", duck_l, 0);
    check("rst_level_chg", level_chg, 0);

    // Inputs held high across release: no debounced activity within DB_CYCLES cycles.
    clr = 1'b0;
    jp0 = jp_cnt; lc0 = lc_cnt;
    ticks(4);
    check("rst_win_paused", paused, 1);
    check("rst_win_pulses", (jp_cnt - jp0) + (lc_cnt - lc0), 0);
    btn = '0;
    num = 3'd0;
    clr = 1'b1;
    ticks(2);
    clr = 1'b0;
    ticks(2);

    press(BPause);
    check("unpause", paused, 0);

    // Clean jump press: pulse after edge 5 only.
    btn[BJump] = 1'b1;
    ticks(5);
    check("jp_early", jump_p, 0);
    tick();
    check("jp_pulse", jump_p, 1);
    tick();
    check("jp_one_cycle", jump_p, 0);
    jp0 = jp_cnt;
    ticks(100);
    check("jp_held", jp_cnt - jp0, 0);
    btn[BJump] = 1'b0;
    ticks(8);
    check("jp_release", jp_cnt - jp0, 0);

    // 3-cycle glitch is rejected.
    jp0 = jp_cnt;
    btn[BJump] = 1'b1;
    ticks(3);
    btn[BJump] = 1'b0;
    ticks(12);
    check("jp_glitch", jp_cnt - jp0, 0);

    // Bounce 1,1,1,0,1,1,1,1 then held: db flips at edge 9.
    pat = 8'b1111_0111;
    jp0 = jp_cnt;
    for (int i = 0; i < 8; i++) begin
      btn[BJump] = pat[i];
      tick();
    end
    check("bounce_none_yet", jp_cnt - jp0, 0);
    tick();
    check("bounce_edge8", jump_p, 0);
    tick();
    check("bounce_edge9", jump_p, 1);
    ticks(20);
    check("bounce_count", jp_cnt - jp0, 1);
    btn[BJump] = 1'b0;
    ticks(8);

    // Pause gating.
    press(BPause);
    check("pause_on", paused, 1);
    jp0 = jp_cnt;
    press(BJump);
    check("jp_paused", jp_cnt - jp0, 0);
    btn[BDuck] = 1'b1;
    ticks(10);
    check("duck_paused", duck_l, 0);
    press(BPause);
    check("pause_off", paused, 0);
    check("duck_unpaused", duck_l, 1);
    btn[BPause] = 1'b1;
    ticks(6);
    check("pause_pre_toggle", paused, 0);
    check("duck_pre_toggle", duck_l, 1);
    tick();
    check("pause_toggle", paused, 1);
    check("duck_drop", duck_l, 0);
    btn[BPause] = 1'b0;
    ticks(8);
    btn[BDuck] = 1'b0;
    ticks(8);

    // Level stepping while paused.
    lc0 = lc_cnt;
    exp_lvl = 3'd1;
    for (int i = 0; i < 7; i++) begin
      press(BChoose);
      exp_lvl = (exp_lvl == 3'd7) ? 3'd1 : exp_lvl + 3'd1;
      check("lvl_step", level, exp_lvl);
    end
    check("lvl_step_chg", lc_cnt - lc0, 7);

    num = 3'd5;
    lc0 = lc_cnt;
    press(BAdj);
    check("adj_5", level, 5);
    check("adj_5_chg", lc_cnt - lc0, 1);
    num = 3'd0;
    press(BAdj);
    check("adj_0", level, 1);
    num = 3'd1;
    lc0 = lc_cnt;
    press(BAdj);
    check("adj_same", level, 1);
    check("adj_same_chg", lc_cnt - lc0, 0);

    // Unpaused: level inputs ignored.
    press(BPause);
    check("unpause2", paused, 0);
    num = 3'd6;
    lc0 = lc_cnt;
    press(BAdj);
    press(BChoose);
    check("lvl_unpaused", level, 1);
    check("lvl_unpaused_chg", lc_cnt - lc0, 0);
    press(BPause);
    check("pause_on2", paused, 1);

    // Simultaneous adj and chooselvl: adj wins.
    num = 3'd3;
    btn[BAdj] = 1'b1;
    btn[BChoose] = 1'b1;
    ticks(16);
    btn[BAdj] = 1'b0;
    btn[BChoose] = 1'b0;
    ticks(8);
    check("simul_level", level, 3);

    // Reset in the middle of a pause debounce.
    btn[BPause] = 1'b1;
    ticks(3);
    clr = 1'b1;
    btn[BPause] = 1'b0;
    tick();
    clr = 1'b0;
    jp0 = jp_cnt; lc0 = lc_cnt;
    ticks(16);
    check("midclr_paused", paused, 1);
    check("midclr_level", level, 1);
    check("midclr_pulses", (jp_cnt - jp0) + (lc_cnt - lc0), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
